// File: rtl/i2c_read_master.sv
// I2C master: START, {DEV_ADDR,R}, address-ACK check, NBYTES reads with master ACK/NACK, STOP.
// Runs (11 + 9*NBYTES)*4*CLK_DIV cycles per request unless the slave stretches SCL; start is ignored while busy.
module i2c_read_master #(
   parameter int         CLK_DIV  = 4,
   parameter logic [6:0] DEV_ADDR = 7'h48,
   parameter int         NBYTES   = 2
) (
   input  logic                clk_10M,
   input  logic                reset,
   input  logic                start,
   output logic                scl_o,
   input  logic                scl_i,
   output logic                sda_oe,
   input  logic                sda_i,
   output logic                busy,
   output logic                done,
   output logic                nack,
   output logic [8*NBYTES-1:0] dout
);

   localparam int              DW        = 8 * NBYTES;
   localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [7:0]      ADDR_BYTE = {DEV_ADDR, 1'b1};
   localparam logic [2:0]      LAST_BYTE = 3'(NBYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_AACK, S_READ, S_MACK, S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [1:0]        ph_q, ph_d;
   logic [2:0]        bit_q, bit_d;
   logic [2:0]        byte_q, byte_d;
   logic [DW-1:0]     shift_q, shift_d;
   logic [DW-1:0]     dout_q, dout_d;
   logic              scl_q, scl_d;
   logic              sda_oe_q, sda_oe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              nack_q, nack_d;
   logic              tick;
   logic              stall;

   assign tick  = (div_q == DIV_LAST);
   // A slave holding SCL low while we release it freezes the phase, not the divider.
   assign stall = ph_q[1] & ~scl_i;

   always_comb begin
      state_d  = state_q;
      div_d    = tick ? '0 : div_q + DIV_W'(1);
      ph_d     = ph_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      shift_d  = shift_q;
      dout_d   = dout_q;
      scl_d    = scl_q;
      sda_oe_d = sda_oe_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      nack_d   = nack_q;

      if (state_q == S_IDLE) begin
         div_d = '0;
         if (start && !done_q) begin
            state_d = S_START;
            busy_d  = 1'b1;
            nack_d  = 1'b0;
            ph_d    = 2'd0;
            bit_d   = 3'd0;
            byte_d  = 3'd0;
            shift_d = '0;
         end
      end else if (tick && !stall) begin
         if (ph_q != 2'd3) begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd1) begin
               scl_d = 1'b1;
               if (state_q == S_START) sda_oe_d = 1'b1;
            end
            if (ph_q == 2'd2) begin
               case (state_q)
                  S_AACK:  nack_d   = sda_i;
                  S_READ:  shift_d  = {shift_q[DW-2:0], sda_i};
                  S_STOP:  sda_oe_d = 1'b0;
                  default: ;
               endcase
            end
         end else begin
            // End of bit: pick the next state and drive SDA for its ph0.
            ph_d  = 2'd0;
            scl_d = 1'b0;
            bit_d = bit_q + 3'd1;
            case (state_q)
               S_START: begin
                  state_d  = S_ADDR;
                  bit_d    = 3'd0;
                  sda_oe_d = ~ADDR_BYTE[7];
               end
               S_ADDR: begin
                  if (bit_q == 3'd7) begin
                     state_d  = S_AACK;
                     sda_oe_d = 1'b0;
                  end else begin
                     sda_oe_d = ~ADDR_BYTE[3'd6 - bit_q];
                  end
               end
               S_AACK: begin
                  bit_d = 3'd0;
                  if (nack_q) begin
                     state_d  = S_STOP;
                     sda_oe_d = 1'b1;
                  end else begin
                     state_d  = S_READ;
                     sda_oe_d = 1'b0;
                  end
               end
               S_READ: begin
                  if (bit_q == 3'd7) begin
                     state_d  = S_MACK;
                     sda_oe_d = (byte_q != LAST_BYTE);
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end
               S_MACK: begin
                  bit_d = 3'd0;
                  if (byte_q == LAST_BYTE) begin
                     state_d  = S_STOP;
                     sda_oe_d = 1'b1;
                  end else begin
                     state_d  = S_READ;
                     byte_d   = byte_q + 3'd1;
                     sda_oe_d = 1'b0;
                  end
               end
               S_STOP: begin
                  state_d = S_IDLE;
                  scl_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  if (!nack_q) dout_d = shift_q;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_10M or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         ph_q     <= 2'd0;
         bit_q    <= 3'd0;
         byte_q   <= 3'd0;
         shift_q  <= '0;
         dout_q   <= '0;
         scl_q    <= 1'b1;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         nack_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         ph_q     <= ph_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         shift_q  <= shift_d;
         dout_q   <= dout_d;
         scl_q    <= scl_d;
         sda_oe_q <= sda_oe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         nack_q   <= nack_d;
      end
   end

   assign scl_o  = scl_q;
   assign sda_oe = sda_oe_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign nack   = nack_q;
   assign dout   = dout_q;

endmodule

// File: tb/tb_i2c_read_master.sv
// Bench for i2c_read_master: a bus-level I2C slave model plus arithmetic timing/data expectations.
`timescale 1ns/1ps
module tb_i2c_read_master;

   localparam int CD     = 4;
   localparam int NB     = 2;
   localparam int T_FULL = (1 + 9 + 9*NB + 1) * 4 * CD + 1;
   localparam int T_NACK = (1 + 9 + 1) * 4 * CD + 1;

   logic            clk_10M = 1'b0;
   logic            reset   = 1'b1;
   logic            start   = 1'b0;
   logic            stretch = 1'b0;
   logic            slave_present = 1'b1;
   logic            slv_pull;
   logic            scl_o, sda_oe, busy, done, nack;
   logic [8*NB-1:0] dout;
   logic            scl_line, sda_line;

   assign scl_line = scl_o & ~stretch;
   assign sda_line = ~sda_oe & ~slv_pull;

   i2c_read_master #(.CLK_DIV(CD), .DEV_ADDR(7'h48), .NBYTES(NB)) dut (
      .clk_10M(clk_10M), .reset(reset), .start(start),
      .scl_o(scl_o), .scl_i(scl_line), .sda_oe(sda_oe), .sda_i(sda_line),
      .busy(busy), .done(done), .nack(nack), .dout(dout)
   );

   always #50 clk_10M = ~clk_10M;

   int cyc = 0, c0 = 0, n_cmp = 0, n_bad = 0;
   logic [8*NB-1:0] model_dout = '0;
   always @(posedge clk_10M) cyc <= cyc + 1;

   function automatic int rc();
      return cyc - c0 + 1;
   endfunction

   // Slave model: watches the wires for START/STOP and SCL edges, answers on SCL falls.
   logic       scl_p, sda_p;
   logic [7:0] addr_rx;
   logic [3:0] mack_rx;
   logic [7:0] tx [0:3];
   int         rises = 0, mack_cnt = 0, n_starts = 0, n_stops = 0;

   function automatic logic drive(input int idx);
      int j, b;
      if (!slave_present || addr_rx != 8'h91) return 1'b0;
      if (idx == 8) return 1'b1;
      if (idx < 9) return 1'b0;
      j = (idx - 9) % 9;
      b = (idx - 9) / 9;
      if (j < 8 && b < NB) return ~tx[b][7-j];
      return 1'b0;
   endfunction

   always @(posedge clk_10M or posedge reset) begin
      if (reset) begin
         slv_pull <= 1'b0;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         scl_p <= scl_line;
         sda_p <= sda_line;
         if (scl_p && scl_line && sda_p && !sda_line) begin
            rises    <= 0;
            mack_cnt <= 0;
            slv_pull <= 1'b0;
            n_starts <= n_starts + 1;
         end else if (scl_p && scl_line && !sda_p && sda_line) begin
            slv_pull <= 1'b0;
            n_stops  <= n_stops + 1;
         end else if (!scl_p && scl_line) begin
            if (rises < 8) addr_rx <= {addr_rx[6:0], sda_line};
            else if (rises >= 9 && (rises - 9) % 9 == 8) begin
               mack_rx[mack_cnt[1:0]] <= sda_line;
               mack_cnt <= mack_cnt + 1;
            end
            rises <= rises + 1;
         end else if (scl_p && !scl_line) begin
            slv_pull <= drive(rises);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk_10M) start = 1'b1;
      @(negedge clk_10M) start = 1'b0;
      c0 = cyc;
   endtask

   task automatic load_bytes(input bit fixed);
      for (int k = 0; k < 4; k++) tx[k] = 8'($urandom);
      if (fixed) begin
         tx[0] = 8'hA5;
         tx[1] = 8'h3C;
      end
   endtask

   function automatic logic [8*NB-1:0] expected_dout();
      logic [8*NB-1:0] e = '0;
      for (int k = 0; k < NB; k++) begin
         e = e << 8;
         e[7:0] = tx[k];
      end
      return e;
   endfunction

   // One request end to end; s_len > 0 stretches SCL from relative cycle s_from.
   task automatic test_read_txn(input string name, input int exp_len, input int tol,
                                input int s_from, input int s_len);
      logic [8*NB-1:0] exp_dout;
      logic            ack;
      int              st0, sp0, dcyc, r;
      bit              seen;
      ack      = slave_present;
      exp_dout = ack ? expected_dout() : model_dout;
      st0 = n_starts;
      sp0 = n_stops;
      seen = 0;
      dcyc = -1;
      pulse_start();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
      for (int i = 0; i < exp_len + 200 && !seen; i++) begin
         @(negedge clk_10M);
         r = rc();
         if (s_len > 0 && r == s_from) stretch = 1'b1;
         if (s_len > 0 && r == s_from + s_len) stretch = 1'b0;
         if (s_len > 0 && r == s_from + 13) begin
            n_cmp++;
            if (scl_o !== 1'b1) begin n_bad++; $display("FAIL %s scl_held_high: got %b want 1", name, scl_o); end
         end
         if (done === 1'b1) begin seen = 1; dcyc = r; end
      end
      stretch = 1'b0;
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s timeout: no done within %0d cycles", name, exp_len + 200);
         return;
      end
      if (dcyc < exp_len - tol || dcyc > exp_len + tol) begin
         n_bad++; $display("FAIL %s done_cycle: got %0d want %0d+/-%0d", name, dcyc, exp_len, tol);
      end
      n_cmp++;
      if (dout !== exp_dout) begin n_bad++; $display("FAIL %s dout: got %h want %h", name, dout, exp_dout); end
      n_cmp++;
      if (nack !== ~ack) begin n_bad++; $display("FAIL %s nack: got %b want %b", name, nack, ~ack); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
      n_cmp++;
      if (addr_rx !== 8'h91) begin n_bad++; $display("FAIL %s addr_byte: got %h want 91", name, addr_rx); end
      n_cmp++;
      if (n_starts - st0 != 1 || n_stops - sp0 != 1) begin
         n_bad++; $display("FAIL %s start_stop: got %0d/%0d want 1/1", name, n_starts - st0, n_stops - sp0);
      end
      if (ack) begin
         n_cmp++;
         if (mack_cnt != NB) begin n_bad++; $display("FAIL %s mack_count: got %0d want %0d", name, mack_cnt, NB); end
         for (int k = 0; k < NB; k++) begin
            n_cmp++;
            if (mack_rx[k] !== (k == NB - 1)) begin
               n_bad++; $display("FAIL %s master_ack%0d: got %b want %b", name, k, mack_rx[k], (k == NB - 1));
            end
         end
      end
      @(negedge clk_10M);
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL %s done_width: got %b want 0", name, done); end
      model_dout = exp_dout;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_10M);
      reset = 1'b0;
      repeat (100) @(negedge clk_10M);
      n_cmp++; if (scl_o  !== 1'b1) begin n_bad++; $display("FAIL reset scl_o: got %b want 1", scl_o); end
      n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL reset sda_oe: got %b want 0", sda_oe); end
      n_cmp++; if (busy   !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
      n_cmp++; if (done   !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
      n_cmp++; if (nack   !== 1'b0) begin n_bad++; $display("FAIL reset nack: got %b want 0", nack); end
      n_cmp++; if (dout   !== '0)   begin n_bad++; $display("FAIL reset dout: got %h want 0", dout); end
   endtask

   task automatic test_basic();
      load_bytes(1);
      test_read_txn("basic", T_FULL, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 3; t++) begin
         load_bytes(0);
         test_read_txn($sformatf("random%0d", t), T_FULL, 0, 0, 0);
      end
   endtask

   task automatic test_no_slave();
      slave_present = 1'b0;
      test_read_txn("no_slave", T_NACK, 0, 0, 0);
      slave_present = 1'b1;
   endtask

   task automatic test_stretch();
      load_bytes(1);
      // byte 0, bit 3 -> bus bit 13; ph2 begins 8 cycles into the bit
      test_read_txn("stretch", T_FULL + 40, CD, 13*4*CD + 2*CD, 40);
   endtask

   task automatic test_back_to_back();
      int ndone, first, second, r;
      load_bytes(0);
      ndone = 0; first = -1; second = -1;
      pulse_start();
      for (int i = 0; i < 2*T_FULL + 100; i++) begin
         @(negedge clk_10M);
         r = rc();
         start = (r == 50 || r == T_FULL || r == T_FULL + 5);
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) first = r;
            if (ndone == 2) second = r;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (ndone != 2) begin n_bad++; $display("FAIL b2b done_count: got %0d want 2", ndone); end
      n_cmp++;
      if (first != T_FULL) begin n_bad++; $display("FAIL b2b first_done: got %0d want %0d", first, T_FULL); end
      n_cmp++;
      if (second != 2*T_FULL + 5) begin n_bad++; $display("FAIL b2b second_done: got %0d want %0d", second, 2*T_FULL + 5); end
      n_cmp++;
      if (dout !== expected_dout()) begin n_bad++; $display("FAIL b2b dout: got %h want %h", dout, expected_dout()); end
      model_dout = expected_dout();
   endtask

   task automatic test_reset_mid();
      load_bytes(0);
      pulse_start();
      while (rc() < 200) @(negedge clk_10M);
      reset = 1'b1;
      #1;
      n_cmp++; if (scl_o  !== 1'b1) begin n_bad++; $display("FAIL midreset scl_o: got %b want 1", scl_o); end
      n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL midreset sda_oe: got %b want 0", sda_oe); end
      n_cmp++; if (busy   !== 1'b0) begin n_bad++; $display("FAIL midreset busy: got %b want 0", busy); end
      repeat (3) @(negedge clk_10M);
      reset = 1'b0;
      model_dout = '0;
      repeat (5) @(negedge clk_10M);
      load_bytes(0);
      test_read_txn("after_reset", T_FULL, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_no_slave();
      test_stretch();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
